// File: rtl/demux1to2_stream.sv
// demux1to2_stream: registered 1-to-2 valid/ready stream demultiplexer.
// Each input word goes to port A (in_sel=0) or port B (in_sel=1). Each port
// has a one-entry holding slot, so one stalled consumer never blocks the other.
// Optional per-port accept counters are enabled by defining DEMUX_STREAM_CNT_EN.
// When it is not defined, a_count and b_count are tied to zero.
module demux1to2_stream #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic             a_valid_q, a_valid_d;
  logic             b_valid_q, b_valid_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic             load_a, load_b;
  logic             drain_a, drain_b;

  // A slot can take a word when it is empty or is being drained this cycle.
  // The result never depends on in_valid.
  always_comb begin
    in_ready = in_sel ? (~b_valid_q | b_ready) : (~a_valid_q | a_ready);
  end

  // Decode accepts and drains for each port
  always_comb begin
    load_a  = in_valid & in_ready & ~in_sel;
    load_b  = in_valid & in_ready &  in_sel;
    drain_a = a_valid_q & a_ready;
    drain_b = b_valid_q & b_ready;
  end

  // Slot next state: a load wins over a drain, so a port can stream 1 word per cycle
  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    if (load_a) begin
      a_valid_d = 1'b1;
      a_data_d  = in_data;
    end else if (drain_a) begin
      a_valid_d = 1'b0;
    end
    if (load_b) begin
      b_valid_d = 1'b1;
      b_data_d  = in_data;
    end else if (drain_b) begin
      b_valid_d = 1'b0;
    end
  end

  // Slot registers; reset discards any word held in a slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
    end
  end

  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign a_data  = a_data_q;
  assign b_data  = b_data_q;

`ifdef DEMUX_STREAM_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;

  // Saturating accept counters; they do not wrap
  always_comb begin
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (load_a && (a_count_q != CNT_MAX)) a_count_d = a_count_q + CNT_W'(1);
    if (load_b && (b_count_q != CNT_MAX)) b_count_d = b_count_q + CNT_W'(1);
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
`else
  assign a_count = '0;
  assign b_count = '0;
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Self-checking bench for demux1to2_stream. It follows DEMUX_STREAM_CNT_EN
// when deciding the expected counter values.
module tb_demux1to2_stream;

`ifdef DEMUX_STREAM_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [8:0]  in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  a_data;
  logic        a_valid;
  logic        a_ready;
  logic [8:0]  b_data;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] a_count;
  logic [15:0] b_count;

  logic        sat_valid;
  logic        sat_in_ready;
  logic [8:0]  sat_a_data;
  logic        sat_a_valid;
  logic [8:0]  sat_b_data;
  logic        sat_b_valid;
  logic [1:0]  sat_a_count;
  logic [1:0]  sat_b_count;

  int checks = 0;
  int errors = 0;

  // Scoreboard: words expected on each port, in acceptance order
  logic [8:0]  qa[$];
  logic [8:0]  qb[$];
  logic [15:0] ca = '0;
  logic [15:0] cb = '0;

  demux1to2_stream #(.WIDTH(9), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  demux1to2_stream #(.WIDTH(9), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_data(9'h03C), .in_sel(1'b0), .in_valid(sat_valid), .in_ready(sat_in_ready),
    .a_data(sat_a_data), .a_valid(sat_a_valid), .a_ready(1'b1),
    .b_data(sat_b_data), .b_valid(sat_b_valid), .b_ready(1'b1),
    .a_count(sat_a_count), .b_count(sat_b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the DUT against the scoreboard at the falling edge,
  // update the scoreboard for the coming rising edge, and return just after that edge.
  task automatic cycle();
    logic exp_rdy;
    @(negedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
      ca = '0;
      cb = '0;
    end else begin
      chk("sb_a_valid", 32'(a_valid), 32'(qa.size() != 0));
      chk("sb_b_valid", 32'(b_valid), 32'(qb.size() != 0));
      if (qa.size() != 0) chk("sb_a_data", 32'(a_data), 32'(qa[0]));
      if (qb.size() != 0) chk("sb_b_data", 32'(b_data), 32'(qb[0]));
      exp_rdy = in_sel ? ((qb.size() == 0) || b_ready) : ((qa.size() == 0) || a_ready);
      chk("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("sb_a_count", 32'(a_count), CNT_ON ? 32'(ca) : 32'd0);
      chk("sb_b_count", 32'(b_count), CNT_ON ? 32'(cb) : 32'd0);
      if ((qa.size() != 0) && a_ready) void'(qa.pop_front());
      if ((qb.size() != 0) && b_ready) void'(qb.pop_front());
      if (in_valid && exp_rdy) begin
        if (in_sel) begin
          qb.push_back(in_data);
          if (cb != 16'hFFFF) cb = cb + 16'd1;
        end else begin
          qa.push_back(in_data);
          if (ca != 16'hFFFF) ca = ca + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = 1'b0;
    in_valid  = 1'b0;
    a_ready   = 1'b1;
    b_ready   = 1'b1;
    sat_valid = 1'b0;

    // Reset, then idle
    @(posedge clk);
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_a_data", 32'(a_data), 32'd0);
    chk("rst_b_data", 32'(b_data), 32'd0);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_count", 32'(b_count), 32'd0);
    rst = 1'b0;
    in_sel = 1'b0;
    #1 chk("idle_in_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1 chk("idle_in_ready_sel1", 32'(in_ready), 32'd1);
    cycle();

    // Single word to A
    in_data = 9'h0A5; in_sel = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("single_a_data", 32'(a_data), 32'h0A5);
    chk("single_a_valid", 32'(a_valid), 32'd1);
    chk("single_b_valid", 32'(b_valid), 32'd0);
    cycle();
    chk("single_a_valid_fall", 32'(a_valid), 32'd0);

    // Back-to-back streaming with alternating select
    for (int i = 1; i <= 8; i++) begin
      in_data = 9'(i); in_sel = (i % 2 == 0); in_valid = 1'b1;
      #1 chk("stream_in_ready", 32'(in_ready), 32'd1);
      cycle();
      if (i % 2 == 0) chk("stream_b_data", 32'(b_data), 32'(i));
      else            chk("stream_a_data", 32'(a_data), 32'(i));
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // A stalled holding 9'h111; B stays open
    a_ready = 1'b0;
    in_data = 9'h111; in_sel = 1'b0; in_valid = 1'b1;
    cycle();
    chk("stall_a_load", 32'(a_data), 32'h111);
    in_data = 9'h055;
    #1 chk("stall_in_ready_sel0", 32'(in_ready), 32'd0);
    cycle();
    cycle();
    chk("stall_a_hold_data", 32'(a_data), 32'h111);
    chk("stall_a_hold_valid", 32'(a_valid), 32'd1);
    in_valid = 1'b0;
    cycle();
    in_data = 9'h1FF; in_sel = 1'b1; in_valid = 1'b1;
    #1 chk("stall_in_ready_sel1", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    chk("stall_b_data", 32'(b_data), 32'h1FF);
    chk("stall_b_valid", 32'(b_valid), 32'd1);
    chk("stall_a_still", 32'(a_data), 32'h111);
    a_ready = 1'b1;
    cycle();
    cycle();
    chk("stall_a_drained", 32'(a_valid), 32'd0);

    // Simultaneous drain and load on B
    b_ready = 1'b0;
    in_data = 9'h0AA; in_sel = 1'b1; in_valid = 1'b1;
    cycle();
    b_ready = 1'b1;
    in_data = 9'h0C3;
    #1 chk("dl_in_ready", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    chk("dl_b_valid", 32'(b_valid), 32'd1);
    chk("dl_b_data", 32'(b_data), 32'h0C3);
    cycle();
    chk("dl_b_empty", 32'(b_valid), 32'd0);

    // Mid-operation asynchronous reset with both slots full
    a_ready = 1'b0; b_ready = 1'b0;
    in_data = 9'h012; in_sel = 1'b0; in_valid = 1'b1;
    cycle();
    in_data = 9'h034; in_sel = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("full_a_valid", 32'(a_valid), 32'd1);
    chk("full_b_valid", 32'(b_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_a_valid", 32'(a_valid), 32'd0);
    chk("arst_b_valid", 32'(b_valid), 32'd0);
    chk("arst_a_data", 32'(a_data), 32'd0);
    chk("arst_b_data", 32'(b_data), 32'd0);
    chk("arst_a_count", 32'(a_count), 32'd0);
    chk("arst_b_count", 32'(b_count), 32'd0);
    cycle();
    rst = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1;
    cycle();

    // Counter saturation with CNT_W=2: five accepts to A
    sat_valid = 1'b1;
    repeat (5) cycle();
    sat_valid = 1'b0;
    cycle();
    chk("sat_a_count", 32'(sat_a_count), CNT_ON ? 32'd3 : 32'd0);
    chk("sat_b_count", 32'(sat_b_count), 32'd0);
    chk("sat_a_data", 32'(sat_a_data), 32'h03C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
